aes_stim_seq: RTL and testbench
===============================

// Module: aes_stim_seq
// PURPOSE
//  Upstream stimulus sequencer for the aes_128 core: generates 128-bit plaintext (state) and key
//  vectors under a valid/ready handshake, for a programmable number of vectors per run.
//  Plaintext advances per accepted vector (counter or LFSR); key advances every KEY_PERIOD vectors.
//  Its outputs replace free-running state/key registers in the AES test top.
// PARAMETERS
//  CNT_W       16       width of num_vectors and the internal vector counter
//  KEY_PERIOD  16       accepted vectors per key increment; 0 = key held constant for the run
//  LFSR_SEED   128'h1   plaintext load value at start in LFSR mode (must be nonzero)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      begin a run; sampled only in IDLE
//  mode         in   1      0 = counter plaintext, 1 = LFSR plaintext; sampled with start
//  num_vectors  in   CNT_W  vectors to emit this run; sampled with start
//  key_seed     in   128    key value loaded at start
//  state_out    out  128    current plaintext vector
//  key_out      out  128    current key vector
//  vec_valid    out  1      state_out/key_out hold a valid vector
//  vec_ready    in   1      consumer accepts vector when vec_valid & vec_ready
//  busy         out  1      high in LOAD and RUN
//  done         out  1      one-cycle pulse when a run completes
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE; state_out, key_out, counters = 0; vec_valid,
//    busy, done = 0.
//  - FSM IDLE -> LOAD on start. LOAD (1 cycle): latch mode, num_vectors, key_seed -> key_out;
//    state_out = 0 (mode 0) or LFSR_SEED (mode 1); vec_cnt = 0, key_cnt = 0.
//    LOAD -> DONE if num_vectors == 0, else -> RUN.
//  - RUN: vec_valid = 1. state_out/key_out stable while vec_valid & !vec_ready.
//    On accept: vec_cnt += 1; plaintext advances (mode 0: +1 mod 2^128, wraps all-ones -> 0;
//    mode 1: Galois LFSR, poly x^128+x^7+x^2+x+1, shift left, XOR 128'h87 when msb was 1).
//    key_cnt += 1; if KEY_PERIOD != 0 and key_cnt reaches KEY_PERIOD: key_out += 1 (mod 2^128),
//    key_cnt = 0. Updates visible the cycle after accept.
//    Accept of vector number num_vectors -> DONE; vec_valid drops that same next cycle.
//  - DONE (1 cycle): done = 1, busy = 0, vec_valid = 0 -> IDLE. Outputs keep last values.
//  - busy = 1 in LOAD and RUN only. start in LOAD/RUN/DONE ignored (no queueing).
//  - Latency start -> first vec_valid: 2 cycles (start sampled, LOAD, RUN).
//  - Run of N vectors with vec_ready held high: exactly N consecutive accept cycles.
//  - rst mid-run: immediate abort to reset values; no done pulse.
//  - Inputs mode/num_vectors/key_seed changing during RUN have no effect.
// CONFIGURATION
//  STIM_LFSR_EN defined: mode input honoured; LFSR logic built as above.
//  STIM_LFSR_EN undefined: mode ignored, counter mode only; LFSR_SEED unused; no LFSR logic.
// TESTING
//  1 rst, start with mode=0, num_vectors=3, key_seed=0, KEY_PERIOD=2, vec_ready=1 -> accepts
//    state 0,1,2; key 0,0,1; done pulses 1 cycle after 3rd accept; busy low in that cycle.
//  2 num_vectors=0 start -> LOAD then done pulse, vec_valid never asserted.
//  3 mode=0, num_vectors=4, vec_ready toggled 1,0,0,1,... -> outputs hold during stalls; exactly 4
//    accepts, values 0..3 in order.
//  4 STIM_LFSR_EN, mode=1, seed 1 -> 1,2,4,...; vector after 128'h8000..0 equals 128'h87.
//  5 assert rst during RUN after 2 accepts -> all outputs 0 same cycle, no done; fresh start OK.
//  6 key_seed all-ones, KEY_PERIOD=1, num_vectors=2 -> key_out all-ones then 0 (wrap); start
//    pulsed mid-run ignored.

Source files
------------

// File: rtl/aes_stim_seq.sv
// aes_stim_seq: stimulus sequencer feeding plaintext/key vectors to the aes_128 core
// under a valid/ready handshake, a programmable number of vectors per run.
// Build option: define STIM_LFSR_EN to honour mode_i and build the LFSR plaintext
// generator; without it the plaintext is always a 128-bit up-counter.
//
// state  | meaning
// IDLE   | waiting for start_i; outputs keep the last run's values
// LOAD   | one cycle: latch run settings, load key seed and initial plaintext
// RUN    | vec_valid_o high; each accept advances plaintext/key
// DONE   | one cycle: done_o pulse, then back to IDLE
module aes_stim_seq #(
  parameter int           CNT_W      = 16,
  parameter int           KEY_PERIOD = 16,
  parameter logic [127:0] LFSR_SEED  = 128'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] num_vectors_i,
  input  logic [127:0]     key_seed_i,
  input  logic             vec_ready_i,
  output logic [127:0]     state_out_o,
  output logic [127:0]     key_out_o,
  output logic             vec_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} fsm_e;

  // KEY_PERIOD of 0 disables key advancement entirely.
  localparam logic [CNT_W-1:0] KP = CNT_W'(KEY_PERIOD);

  fsm_e             fsm_q;
  logic [CNT_W-1:0] num_q, vec_cnt_q, key_cnt_q;
  logic [127:0]     state_q, key_q;
  logic             valid_q, busy_q, done_q;

  logic [127:0]     pt_d;
  logic [CNT_W-1:0] vec_cnt_d, key_cnt_d;
  logic             key_roll;

`ifdef STIM_LFSR_EN
  logic             mode_q;

  // Next plaintext: Galois LFSR (x^128+x^7+x^2+x+1) or +1 counter.
  always_comb begin
    pt_d = state_q + 128'd1;
    if (mode_q) pt_d = {state_q[126:0], 1'b0} ^ (state_q[127] ? 128'h87 : 128'h0);
  end
`else
  logic             unused_mode;
  localparam logic [127:0] UNUSED_SEED = LFSR_SEED;
  assign unused_mode = mode_i ^ UNUSED_SEED[0];

  // Next plaintext: counter mode only in this build.
  always_comb begin
    pt_d = state_q + 128'd1;
  end
`endif

  // Per-accept counter increments and key rollover detection.
  always_comb begin
    vec_cnt_d = vec_cnt_q + CNT_W'(1);
    key_cnt_d = key_cnt_q + CNT_W'(1);
    key_roll  = (KEY_PERIOD != 0) && (key_cnt_d == KP);
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      num_q     <= '0;
      vec_cnt_q <= '0;
      key_cnt_q <= '0;
      state_q   <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef STIM_LFSR_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start_i) begin
            fsm_q  <= S_LOAD;
            busy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          num_q     <= num_vectors_i;
          key_q     <= key_seed_i;
          vec_cnt_q <= '0;
          key_cnt_q <= '0;
`ifdef STIM_LFSR_EN
          mode_q    <= mode_i;
          state_q   <= mode_i ? LFSR_SEED : 128'h0;
`else
          state_q   <= '0;
`endif
          if (num_vectors_i == '0) begin
            fsm_q  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            fsm_q   <= S_RUN;
            valid_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (vec_ready_i) begin
            vec_cnt_q <= vec_cnt_d;
            state_q   <= pt_d;
            if (key_roll) begin
              key_q     <= key_q + 128'd1;
              key_cnt_q <= '0;
            end else begin
              key_cnt_q <= key_cnt_d;
            end
            if (vec_cnt_d == num_q) begin
              fsm_q   <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE:  fsm_q <= S_IDLE;
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign state_out_o = state_q;
  assign key_out_o   = key_q;
  assign vec_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_aes_stim_seq.sv
// Directed bench for aes_stim_seq: one instance with KEY_PERIOD=2, a second with
// KEY_PERIOD=1, both driven by the same stimulus.
module tb_aes_stim_seq;

  logic         clk = 1'b0;
  logic         rst, start, mode, vec_ready;
  logic [15:0]  num;
  logic [127:0] seed;
  logic [127:0] st, ky, st1, ky1;
  logic         vv, bz, dn, vv1, bz1, dn1;

  aes_stim_seq #(.CNT_W(16), .KEY_PERIOD(2), .LFSR_SEED(128'h1)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .num_vectors_i(num),
    .key_seed_i(seed), .vec_ready_i(vec_ready), .state_out_o(st), .key_out_o(ky),
    .vec_valid_o(vv), .busy_o(bz), .done_o(dn));

  aes_stim_seq #(.CNT_W(16), .KEY_PERIOD(1), .LFSR_SEED(128'h1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .num_vectors_i(num),
    .key_seed_i(seed), .vec_ready_i(vec_ready), .state_out_o(st1), .key_out_o(ky1),
    .vec_valid_o(vv1), .busy_o(bz1), .done_o(dn1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] acc_state[$];
  logic [127:0] acc_key[$];
  logic [127:0] acc_key1[$];
  int   first_valid, valid_seen, last_acc, done_seen, done_idx, post_act, hold_viol;
  logic busy_at_done, valid_at_done;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic m, input logic [15:0] n, input logic [127:0] s);
    mode  = m;
    num   = n;
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observe a run cycle by cycle starting in LOAD; records accepts and status.
  task automatic collect(input int max_cyc, input int pat, input bit pulse_start,
                         input bit disturb);
    logic         prev_stall;
    logic [127:0] prev_st, prev_ky;
    acc_state.delete(); acc_key.delete(); acc_key1.delete();
    first_valid = -1; valid_seen = 0; last_acc = -1; done_seen = 0; done_idx = -1;
    post_act = 0; hold_viol = 0; busy_at_done = 1'bx; valid_at_done = 1'bx;
    prev_stall = 1'b0; prev_st = '0; prev_ky = '0;
    for (int i = 0; i < max_cyc; i++) begin
      vec_ready = (pat == 0) ? 1'b1 : (i % 3 == 1);
      start     = pulse_start && (i == 2);
      if (disturb && i >= 1) begin
        num  = 16'd1;
        seed = ~seed;
        mode = ~mode;
      end
      if (prev_stall && (st !== prev_st || ky !== prev_ky)) hold_viol++;
      prev_stall = vv && !vec_ready;
      prev_st = st;
      prev_ky = ky;
      if (vv === 1'b1) begin
        valid_seen++;
        if (first_valid < 0) first_valid = i;
      end
      if (vv === 1'b1 && vec_ready) begin
        acc_state.push_back(st);
        acc_key.push_back(ky);
        acc_key1.push_back(ky1);
        last_acc = i;
      end
      if (done_seen > 0 && i > done_idx && (bz || vv || dn)) post_act++;
      if (dn === 1'b1) begin
        if (done_seen == 0) begin
          done_idx      = i;
          busy_at_done  = bz;
          valid_at_done = vv;
        end
        done_seen++;
      end
      if (done_seen > 0 && i >= done_idx + 3) break;
      tick();
    end
    start     = 1'b0;
    vec_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mode = 1'b0; vec_ready = 1'b0; num = '0; seed = '0;
    tick(); tick();
    total++; if (st !== 128'h0 || ky !== 128'h0) begin bad++;
      $display("FAIL reset_data: state=%0h key=%0h want 0/0", st, ky); end
    total++; if ({vv, bz, dn} !== 3'b000) begin bad++;
      $display("FAIL reset_ctrl: valid/busy/done=%b want 000", {vv, bz, dn}); end
    total++; if (st1 !== 128'h0 || ky1 !== 128'h0 || {vv1, bz1, dn1} !== 3'b000) begin bad++;
      $display("FAIL reset_kp1: state=%0h key=%0h ctrl=%b want zeros", st1, ky1, {vv1, bz1, dn1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_run;
    logic [127:0] es[3] = '{128'd0, 128'd1, 128'd2};
    logic [127:0] ek[3] = '{128'd0, 128'd0, 128'd1};
    logic [127:0] ek1[3] = '{128'd0, 128'd1, 128'd2};
    logic [127:0] g;
    kick(1'b0, 16'd3, 128'h0);
    total++; if (bz !== 1'b1 || vv !== 1'b0) begin bad++;
      $display("FAIL load_status: busy=%b valid=%b want 1/0", bz, vv); end
    collect(30, 0, 1'b0, 1'b0);
    total++; if (first_valid !== 1) begin bad++;
      $display("FAIL first_valid_latency: got %0d want 1", first_valid); end
    total++; if (acc_state.size() !== 3) begin bad++;
      $display("FAIL basic_accepts: got %0d want 3", acc_state.size()); end
    for (int k = 0; k < 3; k++) begin
      g = (k < acc_state.size()) ? acc_state[k] : 'x;
      total++; if (g !== es[k]) begin bad++;
        $display("FAIL basic_state[%0d]: got %0h want %0h", k, g, es[k]); end
      g = (k < acc_key.size()) ? acc_key[k] : 'x;
      total++; if (g !== ek[k]) begin bad++;
        $display("FAIL basic_key[%0d]: got %0h want %0h", k, g, ek[k]); end
      g = (k < acc_key1.size()) ? acc_key1[k] : 'x;
      total++; if (g !== ek1[k]) begin bad++;
        $display("FAIL basic_key_kp1[%0d]: got %0h want %0h", k, g, ek1[k]); end
    end
    total++; if (done_seen !== 1 || done_idx !== 4) begin bad++;
      $display("FAIL basic_done: pulses=%0d at=%0d want 1 at 4", done_seen, done_idx); end
    total++; if (busy_at_done !== 1'b0 || valid_at_done !== 1'b0) begin bad++;
      $display("FAIL basic_done_status: busy=%b valid=%b want 0/0", busy_at_done, valid_at_done); end
    total++; if (post_act !== 0) begin bad++;
      $display("FAIL basic_after_done: activity=%0d want 0", post_act); end
  endtask

  task automatic test_zero_vectors;
    kick(1'b0, 16'd0, 128'h3);
    collect(10, 0, 1'b0, 1'b0);
    total++; if (valid_seen !== 0 || acc_state.size() !== 0) begin bad++;
      $display("FAIL zero_valid: valid cycles=%0d accepts=%0d want 0/0", valid_seen, acc_state.size()); end
    total++; if (done_seen !== 1 || done_idx !== 1) begin bad++;
      $display("FAIL zero_done: pulses=%0d at=%0d want 1 at 1", done_seen, done_idx); end
    total++; if (ky !== 128'h3 || st !== 128'h0) begin bad++;
      $display("FAIL zero_outputs: key=%0h state=%0h want 3/0", ky, st); end
  endtask

  task automatic test_stall;
    logic [127:0] g;
    kick(1'b0, 16'd4, 128'h55);
    collect(40, 1, 1'b0, 1'b1);
    total++; if (acc_state.size() !== 4) begin bad++;
      $display("FAIL stall_accepts: got %0d want 4", acc_state.size()); end
    for (int k = 0; k < 4; k++) begin
      g = (k < acc_state.size()) ? acc_state[k] : 'x;
      total++; if (g !== 128'(k)) begin bad++;
        $display("FAIL stall_state[%0d]: got %0h want %0h", k, g, k); end
    end
    total++; if (hold_viol !== 0) begin bad++;
      $display("FAIL stall_hold: changes during stall=%0d want 0", hold_viol); end
    total++; if (acc_key.size() == 4 && (acc_key[0] !== 128'h55 || acc_key[3] !== 128'h56)) begin bad++;
      $display("FAIL stall_key: first=%0h last=%0h want 55/56", acc_key[0], acc_key[3]); end
    total++; if (done_seen !== 1 || done_idx !== 11) begin bad++;
      $display("FAIL stall_done: pulses=%0d at=%0d want 1 at 11", done_seen, done_idx); end
  endtask

  task automatic test_lfsr;
    logic [127:0] g;
`ifdef STIM_LFSR_EN
    kick(1'b1, 16'd130, 128'h0);
    collect(200, 0, 1'b0, 1'b0);
    total++; if (acc_state.size() !== 130) begin bad++;
      $display("FAIL lfsr_accepts: got %0d want 130", acc_state.size()); end
    for (int k = 0; k < 128; k++) begin
      g = (k < acc_state.size()) ? acc_state[k] : 'x;
      total++; if (g !== (128'h1 << k)) begin bad++;
        $display("FAIL lfsr_state[%0d]: got %0h want %0h", k, g, 128'h1 << k); end
    end
    g = (acc_state.size() > 128) ? acc_state[128] : 'x;
    total++; if (g !== 128'h87) begin bad++;
      $display("FAIL lfsr_feedback: got %0h want 87", g); end
    g = (acc_state.size() > 129) ? acc_state[129] : 'x;
    total++; if (g !== 128'h10e) begin bad++;
      $display("FAIL lfsr_after_feedback: got %0h want 10e", g); end
`else
    kick(1'b1, 16'd3, 128'h0);
    collect(30, 0, 1'b0, 1'b0);
    total++; if (acc_state.size() !== 3) begin bad++;
      $display("FAIL mode_ignored_accepts: got %0d want 3", acc_state.size()); end
    for (int k = 0; k < 3; k++) begin
      g = (k < acc_state.size()) ? acc_state[k] : 'x;
      total++; if (g !== 128'(k)) begin bad++;
        $display("FAIL mode_ignored_state[%0d]: got %0h want %0h", k, g, k); end
    end
`endif
  endtask

  task automatic test_reset_abort;
    logic [127:0] g;
    vec_ready = 1'b1;
    kick(1'b0, 16'd10, 128'h5);
    tick(); tick(); tick();
    total++; if (st !== 128'd2 || vv !== 1'b1) begin bad++;
      $display("FAIL abort_pre: state=%0h valid=%b want 2/1", st, vv); end
    #2 rst = 1'b1;
    #1;
    total++; if (st !== 128'h0 || ky !== 128'h0 || {vv, bz, dn} !== 3'b000) begin bad++;
      $display("FAIL abort_immediate: state=%0h key=%0h ctrl=%b want zeros", st, ky, {vv, bz, dn}); end
    tick(); tick();
    total++; if ({vv, bz, dn} !== 3'b000) begin bad++;
      $display("FAIL abort_no_done: ctrl=%b want 000", {vv, bz, dn}); end
    rst = 1'b0;
    vec_ready = 1'b0;
    tick();
    kick(1'b0, 16'd2, 128'h7);
    collect(20, 0, 1'b0, 1'b0);
    total++; if (acc_state.size() !== 2 || done_seen !== 1) begin bad++;
      $display("FAIL abort_restart: accepts=%0d done=%0d want 2/1", acc_state.size(), done_seen); end
    for (int k = 0; k < 2; k++) begin
      g = (k < acc_state.size()) ? acc_state[k] : 'x;
      total++; if (g !== 128'(k)) begin bad++;
        $display("FAIL abort_restart_state[%0d]: got %0h want %0h", k, g, k); end
      g = (k < acc_key.size()) ? acc_key[k] : 'x;
      total++; if (g !== 128'h7) begin bad++;
        $display("FAIL abort_restart_key[%0d]: got %0h want 7", k, g); end
    end
  endtask

  task automatic test_key_wrap;
    logic [127:0] g;
    kick(1'b0, 16'd2, {128{1'b1}});
    collect(20, 0, 1'b1, 1'b0);
    total++; if (acc_key1.size() !== 2) begin bad++;
      $display("FAIL wrap_accepts: got %0d want 2", acc_key1.size()); end
    g = (acc_key1.size() > 0) ? acc_key1[0] : 'x;
    total++; if (g !== {128{1'b1}}) begin bad++;
      $display("FAIL wrap_key1_first: got %0h want all-ones", g); end
    g = (acc_key1.size() > 1) ? acc_key1[1] : 'x;
    total++; if (g !== 128'h0) begin bad++;
      $display("FAIL wrap_key1_second: got %0h want 0", g); end
    g = (acc_key.size() > 1) ? acc_key[1] : 'x;
    total++; if (g !== {128{1'b1}}) begin bad++;
      $display("FAIL wrap_key_kp2_second: got %0h want all-ones", g); end
    total++; if (done_seen !== 1 || post_act !== 0) begin bad++;
      $display("FAIL wrap_start_ignored: done=%0d activity after=%0d want 1/0", done_seen, post_act); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_vectors();
    test_stall();
    test_lfsr();
    test_reset_abort();
    test_key_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
